// File: rtl/spi_tx_byte_feeder_if.sv
// Bundle between the OLED byte producers / serializer and the byte feeder.
// The feeder itself uses the slave view; upstream logic or a bench uses master.
interface spi_tx_byte_feeder_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             wr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_dc;
  logic             tx_final;
  logic             start;
  logic [WIDTH-1:0] data;
  logic             dc;
  logic             cs;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;
  logic             ovf;
  logic             sync_err;

  modport master (
    output wr, wr_data, wr_dc, tx_final,
    input  start, data, dc, cs, full, empty, level, ovf, sync_err
  );

  modport slave (
    input  wr, wr_data, wr_dc, tx_final,
    output start, data, dc, cs, full, empty, level, ovf, sync_err
  );
endinterface

// File: rtl/spi_tx_byte_feeder.sv
// Queues {D/C, byte} entries for the SSD1331 and reloads the serializer exactly at
// its byte-accept points so queued bytes go out back-to-back; drives chip-select.
module spi_tx_byte_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   i_SCK,
  input  logic                   i_RST,
  spi_tx_byte_feeder_if.slave    bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [WIDTH:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             ovf;

  // Transfer sequencing
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             first;
  logic             first_n;
  logic             chk;
  logic             chk_n;
  logic             boundary;
  logic             sync_err;

  // Registered serializer-facing outputs
  logic             start;
  logic             start_n;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_n;
  logic             dc;
  logic             dc_n;
  logic             cs;
  logic             cs_n;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign push  = bus.wr & ~full;

  // First byte after an idle load is accepted one edge early by the serializer.
  assign boundary = first ? (cnt == CNT_W'(WIDTH - 2)) : (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge i_SCK) begin
    if (push) begin
      mem[wr_ptr] <= {bus.wr_dc, bus.wr_data};
    end
  end

  always_ff @(posedge i_SCK or posedge i_RST) begin
    if (i_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level + LVL_W'(push) - LVL_W'(pop);
      // Fullness is judged before any same-edge pop, so the write is still lost.
      if (bus.wr && full) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_SCK or posedge i_RST) begin
    if (i_RST) begin
      state    <= IDLE;
      cnt      <= '0;
      first    <= 1'b0;
      chk      <= 1'b0;
      sync_err <= 1'b0;
      start    <= 1'b0;
      data     <= '0;
      dc       <= 1'b0;
      cs       <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      first <= first_n;
      chk   <= chk_n;
      start <= start_n;
      data  <= data_n;
      dc    <= dc_n;
      cs    <= cs_n;
      if (chk && !bus.tx_final) begin
        sync_err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    first_n = first;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cnt_n   = '0;
          first_n = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        cnt_n = cnt + 1'b1;
        if (boundary) begin
          if (!empty) begin
            pop     = 1'b1;
            cnt_n   = '0;
            first_n = 1'b0;
          end else begin
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    start_n = start;
    data_n  = data;
    dc_n    = dc;
    cs_n    = cs;
    chk_n   = 1'b0;
    case (state)
      IDLE: begin
        start_n = 1'b0;
        cs_n    = 1'b1;
        if (!empty) begin
          start_n        = 1'b1;
          cs_n           = 1'b0;
          {dc_n, data_n} = mem[rd_ptr];
        end
      end
      SEND: begin
        cs_n = 1'b0;
        if (boundary) begin
          chk_n = 1'b1;
          if (!empty) begin
            start_n        = 1'b1;
            {dc_n, data_n} = mem[rd_ptr];
          end else begin
            start_n = 1'b0;
          end
        end
      end
      DRAIN: begin
        start_n = 1'b0;
        cs_n    = 1'b1;
      end
      default: begin
        start_n = 1'b0;
        cs_n    = 1'b1;
      end
    endcase
  end

  assign bus.start    = start;
  assign bus.data     = data;
  assign bus.dc       = dc;
  assign bus.cs       = cs;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level;
  assign bus.ovf      = ovf;
  assign bus.sync_err = sync_err;

endmodule

// File: tb/tb_spi_tx_byte_feeder.sv
// Bench for spi_tx_byte_feeder: queue/timestamp reference model compared every
// cycle, plus directed sequences with hand-derived literal expectations.
`timescale 1ns/1ps
module tb_spi_tx_byte_feeder;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic sck = 1'b0;
  logic rst = 1'b1;

  spi_tx_byte_feeder_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  spi_tx_byte_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_SCK (sck),
    .i_RST (rst),
    .bus   (bus)
  );

  always #5 sck = ~sck;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of entries, absolute edge numbers for accept points.
  logic [WIDTH:0]   q[$];
  int               m_mode;      // 0 idle, 1 transferring, 2 last-bit drain
  longint           edge_n;
  longint           next_acc;
  longint           chk_at;
  int               pre;
  logic             m_start, m_cs, m_dc, m_ovf, m_err;
  logic [WIDTH-1:0] m_data;

  always @(posedge sck or posedge rst) begin
    if (rst) begin
      q.delete();
      m_mode = 0; edge_n = 0; next_acc = -1; chk_at = -1;
      m_start = 1'b0; m_cs = 1'b1; m_dc = 1'b0; m_data = '0;
      m_ovf = 1'b0; m_err = 1'b0;
    end else begin
      edge_n++;
      pre = q.size();
      if (chk_at == edge_n && !bus.tx_final) m_err = 1'b1;
      if (m_mode == 0) begin
        if (pre > 0) begin
          {m_dc, m_data} = q.pop_front();
          m_start = 1'b1; m_cs = 1'b0;
          next_acc = edge_n + WIDTH - 1;
          m_mode = 1;
        end else begin
          m_start = 1'b0; m_cs = 1'b1;
        end
      end else if (m_mode == 1) begin
        if (edge_n == next_acc) begin
          chk_at = edge_n + 1;
          if (pre > 0) begin
            {m_dc, m_data} = q.pop_front();
            next_acc = edge_n + WIDTH;
          end else begin
            m_start = 1'b0;
            m_mode = 2;
          end
        end
      end else begin
        m_cs = 1'b1;
        m_mode = 0;
      end
      if (bus.wr) begin
        if (pre == DEPTH) m_ovf = 1'b1;
        else q.push_back({bus.wr_dc, bus.wr_data});
      end
    end
  end

  always @(negedge sck) begin
    if (cmp_en && !rst) begin
      chk("start", 32'(bus.start), 32'(m_start));
      chk("data", 32'(bus.data), 32'(m_data));
      chk("dc", 32'(bus.dc), 32'(m_dc));
      chk("cs", 32'(bus.cs), 32'(m_cs));
      chk("level", 32'(bus.level), 32'(q.size()));
      chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
      chk("empty", 32'(bus.empty), 32'(q.size() == 0));
      chk("ovf", 32'(bus.ovf), 32'(m_ovf));
      chk("sync_err", 32'(bus.sync_err), 32'(m_err));
    end
  end

  task automatic tick(input logic wr, input logic [WIDTH-1:0] d, input logic dcv);
    bus.wr = wr; bus.wr_data = d; bus.wr_dc = dcv;
    @(posedge sck);
    @(negedge sck);
  endtask

  task automatic do_reset();
    bus.wr = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_start", 32'(bus.start), 32'h0);
    chk("rst_data", 32'(bus.data), 32'h0);
    chk("rst_dc", 32'(bus.dc), 32'h0);
    chk("rst_cs", 32'(bus.cs), 32'h1);
    chk("rst_empty", 32'(bus.empty), 32'h1);
    chk("rst_full", 32'(bus.full), 32'h0);
    chk("rst_level", 32'(bus.level), 32'h0);
    chk("rst_ovf", 32'(bus.ovf), 32'h0);
    chk("rst_sync_err", 32'(bus.sync_err), 32'h0);
    @(negedge sck);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(m_mode == 0 && q.size() == 0) && n < 300) begin
      tick(1'b0, '0, 1'b0);
      n++;
    end
    chk("idle_timeout", 32'(n < 300), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr = 1'b0; bus.wr_data = '0; bus.wr_dc = 1'b0; bus.tx_final = 1'b1;
    @(negedge sck); @(negedge sck);
    rst = 1'b0;
    cmp_en = 1'b1;
    do_reset();

    // Single byte into an idle block
    tick(1'b1, 8'hA5, 1'b0);
    chk("t2_level", 32'(bus.level), 32'h1);
    tick(1'b0, '0, 1'b0);
    chk("t2_start", 32'(bus.start), 32'h1);
    chk("t2_data", 32'(bus.data), 32'hA5);
    chk("t2_cs", 32'(bus.cs), 32'h0);
    chk("t2_mdl_data", 32'(m_data), 32'hA5);
    for (int k = 2; k <= 7; k++) begin
      tick(1'b0, '0, 1'b0);
      chk("t2_start_hold", 32'(bus.start), 32'h1);
    end
    tick(1'b0, '0, 1'b0);
    chk("t2_start_end", 32'(bus.start), 32'h0);
    chk("t2_cs_drain", 32'(bus.cs), 32'h0);
    chk("t2_mdl_start_end", 32'(m_start), 32'h0);
    tick(1'b0, '0, 1'b0);
    chk("t2_cs_idle", 32'(bus.cs), 32'h1);

    // Three back-to-back entries
    tick(1'b1, 8'hAE, 1'b0);
    tick(1'b1, 8'h81, 1'b0);
    chk("t3_d0", 32'(bus.data), 32'hAE);
    tick(1'b1, 8'h3C, 1'b1);
    for (int k = 3; k <= 24; k++) begin
      tick(1'b0, '0, 1'b0);
      if (k == 7)  chk("t3_d0_hold", 32'(bus.data), 32'hAE);
      if (k == 8)  chk("t3_d1", 32'({bus.dc, bus.data}), 32'h081);
      if (k == 15) chk("t3_d1_hold", 32'(bus.data), 32'h81);
      if (k == 16) chk("t3_d2", 32'({bus.dc, bus.data}), 32'h13C);
      if (k == 23) chk("t3_start_last", 32'(bus.start), 32'h1);
      if (k == 24) chk("t3_start_off", 32'(bus.start), 32'h0);
    end
    wait_idle();
    chk("t3_sync_err", 32'(bus.sync_err), 32'h0);

    // Overflow with DEPTH=4: six consecutive writes
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 8'(8'h10 + i), 1'(i));
      if (i == 4) chk("t4_full", 32'(bus.full), 32'h1);
      if (i == 5) begin
        chk("t4_ovf", 32'(bus.ovf), 32'h1);
        chk("t4_level", 32'(bus.level), 32'h4);
      end
    end
    for (int k = 6; k <= 41; k++) begin
      tick(1'b0, '0, 1'b0);
      if (k == 8 || k == 16 || k == 24 || k == 32)
        chk("t4_order", 32'(bus.data), 32'(8'h10 + k / 8));
      if (k == 41) chk("t4_cs_end", 32'(bus.cs), 32'h1);
    end

    // Missing final-bit flag
    do_reset();
    bus.tx_final = 1'b0;
    tick(1'b1, 8'h11, 1'b0);
    tick(1'b1, 8'h22, 1'b1);
    for (int k = 2; k <= 9; k++) begin
      tick(1'b0, '0, 1'b0);
      if (k == 8) chk("t5_err_before", 32'(bus.sync_err), 32'h0);
      if (k == 9) chk("t5_err_set", 32'(bus.sync_err), 32'h1);
    end
    bus.tx_final = 1'b1;
    wait_idle();
    chk("t5_err_sticky", 32'(bus.sync_err), 32'h1);

    // Relaunch after drain keeps first-byte spacing
    do_reset();
    tick(1'b1, 8'h33, 1'b0);
    wait_idle();
    tick(1'b1, 8'h5A, 1'b0);
    tick(1'b0, '0, 1'b0);
    chk("t6_launch", 32'({bus.start, bus.data}), 32'h15A);
    for (int k = 2; k <= 7; k++) tick(1'b0, '0, 1'b0);
    chk("t6_start_hold", 32'(bus.start), 32'h1);
    tick(1'b0, '0, 1'b0);
    chk("t6_start_off", 32'(bus.start), 32'h0);
    wait_idle();
    chk("t6_sync_err", 32'(bus.sync_err), 32'h0);

    // Randomized traffic, with mid-stream async resets
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        bus.tx_final = (r == 2) ? ($urandom_range(0, 9) != 0) : 1'b1;
        tick($urandom_range(0, 99) < (r == 1 ? 70 : 25), WIDTH'($urandom), 1'($urandom));
        if (c == 211) do_reset();
      end
      bus.tx_final = 1'b1;
      wait_idle();
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
